// File: rtl/sig_dump_pkg.sv
// Shared types and default addresses for the signature dumper.
package sig_dump_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_SEND,
    S_DONE
  } sig_state_e;

  localparam logic [31:0] DEF_BEGIN_PTR = 32'h0000_3FF0;
  localparam logic [31:0] DEF_END_PTR   = 32'h0000_3FF4;
  localparam logic [31:0] DEF_MIN_BEGIN = 32'd16;

endpackage

// File: rtl/sig_dump.sv
// Signature dumper: snoops the begin/end signature pointer writes, then reads
// the described region word by word and streams it out on valid/ready.
module sig_dump
  import sig_dump_pkg::*;
#(
  parameter int unsigned RAM_AW    = 22,
  parameter logic [31:0] BEGIN_PTR = DEF_BEGIN_PTR,
  parameter logic [31:0] END_PTR   = DEF_END_PTR,
  parameter logic [31:0] MIN_BEGIN = DEF_MIN_BEGIN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [RAM_AW-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  output logic              rd_req,
  output logic [RAM_AW-3:0] rd_addr,
  input  logic              rd_gnt,
  input  logic [31:0]       rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_last,
  input  logic              rearm,
  output logic              busy,
  output logic              done,
  output logic [RAM_AW-3:0] word_count
);

  sig_state_e        state_q, state_d;
  logic [31:0]       beg_q, end_q, addr_q;
  logic [RAM_AW-3:0] word_count_q;
  logic              trigger;

  // Region is valid once end lies above begin and begin clears the floor.
  assign trigger    = (end_q > beg_q) && (beg_q > MIN_BEGIN);
  assign rd_addr    = (state_q == S_READ) ? addr_q[RAM_AW-1:2] : '0;
  assign word_count = word_count_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    rd_req    = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: if (trigger) state_d = S_READ;
      S_READ: begin
        rd_req = 1'b1;
        busy   = 1'b1;
        if (rd_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        busy    = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) state_d = out_last ? S_DONE : S_READ;
      end
      S_DONE: begin
        done = 1'b1;
        if (rearm) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pointer snoop, walk address, output word register and stream counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      beg_q        <= '0;
      end_q        <= '0;
      addr_q       <= '0;
      out_data     <= '0;
      out_last     <= 1'b0;
      word_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wr_en && (wr_addr == BEGIN_PTR[RAM_AW-1:0])) beg_q <= wr_data;
          else if (wr_en && (wr_addr == END_PTR[RAM_AW-1:0])) end_q <= wr_data;
          if (trigger) addr_q <= {beg_q[31:2], 2'b00};
        end
        S_WAIT: begin
          out_data <= rd_data;
          // A partial trailing word still counts, hence >= rather than ==.
          out_last <= ((addr_q + 32'd4) >= end_q);
        end
        S_SEND: begin
          if (out_ready) begin
            word_count_q <= word_count_q + (RAM_AW-2)'(1);
            if (!out_last) addr_q <= addr_q + 32'd4;
          end
        end
        S_DONE: begin
          if (rearm) begin
            beg_q        <= '0;
            end_q        <= '0;
            word_count_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sig_dump.sv
// Bench for sig_dump: RAM model, scoreboard of expected stream words, and
// directed plus randomized dumps.
module tb_sig_dump;

  localparam int unsigned AW = 22;
  localparam logic [31:0] BP = 32'h3FF0;
  localparam logic [31:0] EP = 32'h3FF4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [31:0]   wr_data = '0;
  logic          rd_req;
  logic [AW-3:0] rd_addr;
  logic          rd_gnt = 1'b1;
  logic [31:0]   rd_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_data;
  logic          out_last;
  logic          rearm = 1'b0;
  logic          busy;
  logic          done;
  logic [AW-3:0] word_count;

  sig_dump #(.RAM_AW(AW), .BEGIN_PTR(BP), .END_PTR(EP), .MIN_BEGIN(32'd16)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .rearm(rearm), .busy(busy), .done(done),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit rnd_en   = 1'b0;

  typedef struct { logic [31:0] data; logic last; } exp_t;
  exp_t q[$];

  logic [31:0] m_beg = '0, m_end = '0;
  bit          m_idle = 1'b1;

  function automatic logic [31:0] mem_word(input logic [AW-3:0] wa);
    return (32'(wa) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_en) begin
      rd_gnt    = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Reference: the region is every word whose address lies in [begin&~3, end).
  task automatic model_trigger();
    logic [32:0] a;
    if (m_idle && (m_end > m_beg) && (m_beg > 32'd16)) begin
      for (a = {1'b0, m_beg[31:2], 2'b00}; a < {1'b0, m_end}; a = a + 33'd4)
        q.push_back('{data: mem_word(a[AW-1:2]), last: ((a + 33'd4) >= {1'b0, m_end})});
      m_idle = 1'b0;
    end
  endtask

  task automatic write_ptr_nogap(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_data = d;
    tick();
    wr_en = 1'b0; wr_data = $urandom;
    if (m_idle) begin
      if (a == BP) m_beg = d;
      else if (a == EP) m_end = d;
      model_trigger();
    end
  endtask

  task automatic write_ptr(input logic [31:0] a, input logic [31:0] d);
    write_ptr_nogap(a, d);
    tick();
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin tick(); n++; end
    chk("done_reached", {31'b0, done}, 32'd1);
    chk("queue_empty", q.size(), 32'd0);
  endtask

  task automatic do_rearm();
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
    m_idle = 1'b1; m_beg = '0; m_end = '0;
    chk("rearm_done", {31'b0, done}, 32'd0);
    chk("rearm_wc", 32'(word_count), 32'd0);
    chk("rearm_busy", {31'b0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    m_idle = 1'b1; m_beg = '0; m_end = '0;
    chk("rst_rd_req", {31'b0, rd_req}, 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_last", {31'b0, out_last}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
  endtask

  // RAM model: data appears the cycle after an accepted request, noise otherwise.
  bit            gnt_seen = 1'b0;
  logic [AW-3:0] gaddr = '0;
  always @(negedge clk) begin
    gnt_seen = rd_req && rd_gnt;
    gaddr    = rd_addr;
  end
  always @(posedge clk) begin
    #1;
    rd_data = gnt_seen ? mem_word(gaddr) : $urandom;
  end

  // Monitor: pops the scoreboard on each accepted word and checks hold rules.
  bit            hold_v = 1'b0, hold_r = 1'b0;
  logic [31:0]   hold_d = '0;
  logic          hold_l = 1'b0;
  logic [AW-3:0] hold_a = '0;
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
      hold_r = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_out_valid", {31'b0, out_valid}, 32'd1);
        chk("hold_out_data", out_data, hold_d);
        chk("hold_out_last", {31'b0, out_last}, {31'b0, hold_l});
      end
      if (hold_r) begin
        chk("hold_rd_req", {31'b0, rd_req}, 32'd1);
        chk("hold_rd_addr", 32'(rd_addr), 32'(hold_a));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_word", out_data, 32'hDEAD_0000);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("stream_data", out_data, e.data);
          chk("stream_last", {31'b0, out_last}, {31'b0, e.last});
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      hold_l = out_last;
      hold_r = rd_req && !rd_gnt;
      hold_a = rd_addr;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int exp_n;
    logic [31:0] b, e;

    repeat (3) tick();
    do_reset();

    // Basic dump with start latency and 3-cycle-per-word throughput.
    write_ptr(BP, 32'h100);
    write_ptr_nogap(EP, 32'h10C);
    chk("basic_rd_req_n1", {31'b0, rd_req}, 32'd0);
    tick();
    chk("basic_rd_req_n2", {31'b0, rd_req}, 32'd1);
    chk("basic_rd_addr", 32'(rd_addr), 32'h40);
    chk("basic_busy", {31'b0, busy}, 32'd1);
    repeat (8) tick();
    chk("basic_last_send", {31'b0, out_valid & out_last}, 32'd1);
    chk("basic_not_done", {31'b0, done}, 32'd0);
    tick();
    chk("basic_done", {31'b0, done}, 32'd1);
    chk("basic_wc", 32'(word_count), 32'd3);
    chk("basic_queue", q.size(), 32'd0);
    do_rearm();

    // Threshold: begin at the floor never triggers; rearm in IDLE is ignored.
    write_ptr(BP, 32'h10);
    write_ptr(EP, 32'h20);
    bad = 0;
    repeat (100) begin
      if (rd_req || busy) bad++;
      tick();
    end
    chk("threshold_idle", bad, 32'd0);
    rearm = 1'b1; tick(); rearm = 1'b0;
    write_ptr(BP, 32'h14);
    wait_done(100);
    chk("threshold_wc", 32'(word_count), 32'd3);
    do_rearm();

    // Backpressure in SEND.
    out_ready = 1'b0;
    write_ptr(BP, 32'h200);
    write_ptr(EP, 32'h208);
    bad = 0;
    while (!out_valid && bad < 20) begin tick(); bad++; end
    chk("bp_valid_seen", {31'b0, out_valid}, 32'd1);
    repeat (5) begin
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_data", out_data, mem_word(20'h80));
      chk("bp_no_rd_req", {31'b0, rd_req}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    wait_done(100);
    chk("bp_wc", 32'(word_count), 32'd2);
    do_rearm();

    // Grant stall.
    rd_gnt = 1'b0;
    write_ptr(BP, 32'h300);
    write_ptr(EP, 32'h304);
    bad = 0;
    while (!rd_req && bad < 20) begin tick(); bad++; end
    repeat (4) begin
      chk("gs_rd_req", {31'b0, rd_req}, 32'd1);
      chk("gs_rd_addr", 32'(rd_addr), 32'hC0);
      tick();
    end
    rd_gnt = 1'b1;
    wait_done(100);
    chk("gs_wc", 32'(word_count), 32'd1);
    do_rearm();

    // Reset mid-dump after the first accepted word.
    write_ptr(BP, 32'h400);
    write_ptr(EP, 32'h410);
    bad = 0;
    while (word_count != 1 && bad < 30) begin tick(); bad++; end
    chk("mid_wc1", 32'(word_count), 32'd1);
    do_reset();
    bad = 0;
    repeat (20) begin
      if (rd_req || busy || out_valid) bad++;
      tick();
    end
    chk("mid_ptrs_cleared", bad, 32'd0);
    write_ptr(BP, 32'h400);
    write_ptr(EP, 32'h410);
    wait_done(100);
    chk("mid_wc", 32'(word_count), 32'd4);
    do_rearm();

    // Ignored pointer write during a dump, unaligned end.
    write_ptr(BP, 32'h100);
    write_ptr(EP, 32'h10E);
    chk("ign_busy", {31'b0, busy}, 32'd1);
    write_ptr(EP, 32'h200);
    wait_done(100);
    chk("ign_wc", 32'(word_count), 32'd4);
    do_rearm();

    // Randomized regions with random grant/ready stalls.
    rnd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b = 32'h20 + $urandom_range(0, 1023);
      e = b + $urandom_range(1, 40);
      write_ptr(BP, b);
      write_ptr(EP, e);
      exp_n = q.size();
      wait_done(800);
      chk("rand_wc", 32'(word_count), 32'(exp_n));
      do_rearm();
    end
    rnd_en = 1'b0;
    rd_gnt = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
